dm_secded_seq: RTL and testbench

Sequencer that drives the SECDED syndrome classifier over a block of encoded words in data memory. On Start it reads each 16-bit Hamming(16,11) codeword as two bytes and forms the 4-bit syndrome and the overall-parity bit. It classifies the codeword, corrects a single-bit error, and writes the 11 decoded data bits plus a 2-bit status flag back to data memory as two bytes. It owns the data-memory port while Busy; the host drives memory only in IDLE.

---
 rtl/secded_pkg.sv | 51 +++++
 rtl/secded_classify.sv | 27 ++
 rtl/dm_secded_seq.sv | 196 +++++++++++++++++++
 tb/tb_dm_secded_seq.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
// Shared definitions for the SECDED block sequencer.
//   - FSM state enum
//   - classifier code and status flag constants
//   - Hamming(16,11) data-bit position table and helpers
package secded_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdLo,
        StRdHi,
        StCapt,
        StEval,
        StWrLo,
        StWrHi,
        StDone
    } state_e;

    localparam logic [3:0] CODE_CLEAN = 4'd0;
    localparam logic [3:0] CODE_PAR   = 4'd12;
    localparam logic [3:0] CODE_DBL   = 4'd13;

    localparam logic [1:0] FLAG_OK  = 2'b00;
    localparam logic [1:0] FLAG_FIX = 2'b01;
    localparam logic [1:0] FLAG_DBL = 2'b10;

    localparam int NUM_DATA = 11;

    // Codeword bit position of data bit d(k+1).
    localparam logic [3:0] DATA_POS [NUM_DATA] = '{
        4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    function automatic logic [10:0] extract_data(input logic [15:0] cw);
        logic [10:0] d;
        d = '0;
        for (int k = 0; k < NUM_DATA; k++) begin
            d[k] = cw[DATA_POS[k]];
        end
        return d;
    endfunction

    function automatic logic [1:0] code_to_flag(input logic [3:0] code);
        if (code == CODE_CLEAN) begin
            return FLAG_OK;
        end else if (code == CODE_DBL) begin
            return FLAG_DBL;
        end
        return FLAG_FIX;
    endfunction

endpackage

// File: rtl/secded_classify.sv
// Combinational SECDED classifier.
//   i_parity   : overall parity of the 16-bit codeword
//   i_syndrome : XOR of set bit positions 1..15
//   o_code     : 0 clean, 1..11 flipped data bit, 12 parity-only, 13 double error
module secded_classify
    import secded_pkg::*;
(
    input  logic       i_parity,
    input  logic [3:0] i_syndrome,
    output logic [3:0] o_code
);

    always_comb begin
        o_code = CODE_PAR;
        if (!i_parity) begin
            o_code = (i_syndrome == 4'd0) ? CODE_CLEAN : CODE_DBL;
        end else begin
            // Syndromes 0,1,2,4,8 match no data position and stay CODE_PAR.
            for (int k = 0; k < NUM_DATA; k++) begin
                if (DATA_POS[k] == i_syndrome) begin
                    o_code = 4'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/dm_secded_seq.sv
// Data-memory SECDED sequencer: reads NWORDS Hamming(16,11) codewords (two bytes each, LSB
// first) from IN_BASE, corrects single-bit errors, and writes {flag, data} as two bytes to
// OUT_BASE. Optional macro SECDED_STATS_EN enables the corrected/uncorrectable counters.
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_start              : begin a run (sampled only when idle)
//   o_busy, o_done       : busy in every non-idle state; one-cycle end-of-run pulse
//   o_mem_addr/_wr_en/_wr_data, i_mem_rd_data : data-memory port (synchronous read)
//   o_sgl_cnt, o_dbl_cnt : corrected / uncorrectable word counts of the last run
module dm_secded_seq
    import secded_pkg::*;
#(
    parameter int unsigned W        = 8,
    parameter int unsigned NWORDS   = 15,
    parameter int unsigned IN_BASE  = 30,
    parameter int unsigned OUT_BASE = 0,
    localparam int unsigned CW      = $clog2(NWORDS + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic [W-1:0]  o_mem_addr,
    output logic          o_mem_wr_en,
    output logic [W-1:0]  o_mem_wr_data,
    input  logic [W-1:0]  i_mem_rd_data,
    output logic [CW-1:0] o_sgl_cnt,
    output logic [CW-1:0] o_dbl_cnt
);

    state_e       r_state;
    logic         r_busy;
    logic         r_done;
    logic         r_we;
    logic [W-1:0] r_addr;
    logic [W-1:0] r_wdata;
    logic [6:0]   r_idx;
    logic [7:0]   r_lo;
    logic [7:0]   r_hi;
    logic [7:0]   r_out_hi;

    logic [15:0]  w_cw;
    logic [3:0]   w_syn;
    logic         w_par;
    logic [3:0]   w_code;
    logic [1:0]   w_flag;
    logic [10:0]  w_data;
    logic [7:0]   w_out_lo;
    logic [7:0]   w_out_hi;
    logic [6:0]   w_idx_nxt;
    logic [W-1:0] w_wr_base;
    logic [W-1:0] w_rd_next;

    assign w_cw = {r_hi, r_lo};

    always_comb begin
        w_syn = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (w_cw[k]) begin
                w_syn = w_syn ^ 4'(k);
            end
        end
    end

    assign w_par = ^w_cw;

    secded_classify u_classify (
        .i_parity   (w_par),
        .i_syndrome (w_syn),
        .o_code     (w_code)
    );

    assign w_flag = code_to_flag(w_code);

    always_comb begin
        w_data = extract_data(w_cw);
        if (w_code >= 4'd1 && w_code <= 4'd11) begin
            w_data[w_code - 4'd1] = ~w_data[w_code - 4'd1];
        end
    end

    assign w_out_lo  = w_data[7:0];
    assign w_out_hi  = {w_flag, 3'b000, w_data[10:8]};

    // Addresses wrap modulo 2^W through truncation.
    assign w_idx_nxt = r_idx + 7'd1;
    assign w_wr_base = W'(OUT_BASE) + W'({r_idx, 1'b0});
    assign w_rd_next = W'(IN_BASE) + W'({w_idx_nxt, 1'b0});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_idx    <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_out_hi <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state <= StRdLo;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                        r_addr  <= W'(IN_BASE);
                    end
                end
                StRdLo: begin
                    r_state <= StRdHi;
                    r_addr  <= r_addr + W'(1);
                end
                StRdHi: begin
                    r_state <= StCapt;
                    r_lo    <= i_mem_rd_data[7:0];
                end
                StCapt: begin
                    r_state <= StEval;
                    r_hi    <= i_mem_rd_data[7:0];
                end
                StEval: begin
                    // Low byte goes straight out; high byte is held for the next write.
                    r_state  <= StWrLo;
                    r_we     <= 1'b1;
                    r_addr   <= w_wr_base;
                    r_wdata  <= W'(w_out_lo);
                    r_out_hi <= w_out_hi;
                end
                StWrLo: begin
                    r_state <= StWrHi;
                    r_addr  <= r_addr + W'(1);
                    r_wdata <= W'(r_out_hi);
                end
                StWrHi: begin
                    r_we    <= 1'b0;
                    r_wdata <= '0;
                    if (r_idx == 7'(NWORDS - 1)) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= StRdLo;
                        r_idx   <= w_idx_nxt;
                        r_addr  <= w_rd_next;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_mem_addr    = r_addr;
    assign o_mem_wr_en   = r_we;
    assign o_mem_wr_data = r_wdata;

`ifdef SECDED_STATS_EN
    logic [CW-1:0] r_sgl;
    logic [CW-1:0] r_dbl;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sgl <= '0;
            r_dbl <= '0;
        end else if (r_state == StIdle && i_start) begin
            r_sgl <= '0;
            r_dbl <= '0;
        end else if (r_state == StEval) begin
            if (w_flag == FLAG_FIX && r_sgl != CW'(NWORDS)) begin
                r_sgl <= r_sgl + CW'(1);
            end
            if (w_flag == FLAG_DBL && r_dbl != CW'(NWORDS)) begin
                r_dbl <= r_dbl + CW'(1);
            end
        end
    end

    assign o_sgl_cnt = r_sgl;
    assign o_dbl_cnt = r_dbl;
`else
    assign o_sgl_cnt = '0;
    assign o_dbl_cnt = '0;
`endif

endmodule

// File: tb/tb_dm_secded_seq.sv
module tb_dm_secded_seq;

    localparam int unsigned NW       = 15;
    localparam int unsigned IN_BASE  = 30;
    localparam int unsigned OUT_BASE = 0;
    localparam int unsigned CWA      = $clog2(NW + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: full 15-word configuration. DUT B: single-word configuration.
    logic           a_start = 1'b0, a_busy, a_done, a_we;
    logic [7:0]     a_addr, a_wdata, a_rd;
    logic [CWA-1:0] a_sgl, a_dbl;
    logic           b_start = 1'b0, b_busy, b_done, b_we;
    logic [7:0]     b_addr, b_wdata, b_rd;
    logic [0:0]     b_sgl, b_dbl;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic       host_we = 1'b0, host_sel = 1'b0;
    logic [7:0] host_addr = '0, host_data = '0;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] words [NW];

    dm_secded_seq #(.W(8), .NWORDS(NW), .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .o_busy(a_busy), .o_done(a_done),
        .o_mem_addr(a_addr), .o_mem_wr_en(a_we), .o_mem_wr_data(a_wdata),
        .i_mem_rd_data(a_rd), .o_sgl_cnt(a_sgl), .o_dbl_cnt(a_dbl)
    );

    dm_secded_seq #(.W(8), .NWORDS(1), .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .o_busy(b_busy), .o_done(b_done),
        .o_mem_addr(b_addr), .o_mem_wr_en(b_we), .o_mem_wr_data(b_wdata),
        .i_mem_rd_data(b_rd), .o_sgl_cnt(b_sgl), .o_dbl_cnt(b_dbl)
    );

    always @(posedge clk) begin
        if (a_we) mem_a[a_addr] <= a_wdata;
        if (b_we) mem_b[b_addr] <= b_wdata;
        if (host_we) begin
            if (host_sel) mem_b[host_addr] <= host_data;
            else          mem_a[host_addr] <= host_data;
        end
        a_rd <= mem_a[a_addr];
        b_rd <= mem_b[b_addr];
    end

    // Reference decoder: {hi, lo} output bytes for one codeword.
    function automatic logic [15:0] ref_decode(input logic [15:0] cw);
        int          s;
        logic        p;
        logic [15:0] c;
        logic [1:0]  flag;
        logic [10:0] d;
        int          n;
        s = 0;
        for (int k = 1; k < 16; k++) if (cw[k]) s = s ^ k;
        p = ^cw;
        c = cw;
        if (!p) begin
            flag = (s == 0) ? 2'b00 : 2'b10;
        end else begin
            flag = 2'b01;
            if (s != 0 && (s & (s - 1)) != 0) c[s] = ~c[s];
        end
        n = 0;
        d = '0;
        for (int k = 1; k < 16; k++) begin
            if ((k & (k - 1)) != 0) begin
                d[n] = c[k];
                n++;
            end
        end
        return {flag, 3'b000, d[10:8], d[7:0]};
    endfunction

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        int          n;
        logic        x;
        c = '0;
        n = 0;
        for (int k = 1; k < 16; k++) begin
            if ((k & (k - 1)) != 0) begin
                c[k] = d[n];
                n++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            x = 1'b0;
            for (int k = 1; k < 16; k++) if ((k & (1 << j)) != 0 && k != (1 << j)) x = x ^ c[k];
            c[1 << j] = x;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [15:0] rand_word(input int kind);
        logic [15:0] c;
        int          a, b;
        c = encode(11'($urandom));
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        if (kind >= 1) c[a] = ~c[a];
        if (kind >= 2) c[b] = ~c[b];
        return c;
    endfunction

    task automatic host_wr(input logic sel, input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        host_we = 1'b1; host_sel = sel; host_addr = addr; host_data = data;
        @(posedge clk);
        #1 host_we = 1'b0;
    endtask

    task automatic load_a();
        for (int i = 0; i < int'(NW); i++) begin
            host_wr(1'b0, 8'(IN_BASE + 2 * i), words[i][7:0]);
            host_wr(1'b0, 8'(IN_BASE + 2 * i + 1), words[i][15:8]);
            host_wr(1'b0, 8'(OUT_BASE + 2 * i), 8'hEE);
            host_wr(1'b0, 8'(OUT_BASE + 2 * i + 1), 8'hEE);
        end
    endtask

    task automatic test_reset();
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_we !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: busy/done/we=%b%b%b required 000", a_busy, a_done, a_we);
        end
        n_checks++;
        if (a_addr !== 8'h00 || a_wdata !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_mem: addr=%h wdata=%h required 00 00", a_addr, a_wdata);
        end
        n_checks++;
        if (a_sgl !== '0 || a_dbl !== '0 || b_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_cnt: sgl=%0d dbl=%0d b_busy=%b required 0 0 0", a_sgl, a_dbl,
                     b_busy);
        end
        n_checks++;
    endtask

    task automatic test_single(input logic [15:0] cw);
        logic [15:0] exp;
        int          exp_s, exp_d;
        exp = ref_decode(cw);
        host_wr(1'b1, 8'(IN_BASE), cw[7:0]);
        host_wr(1'b1, 8'(IN_BASE + 1), cw[15:8]);
        host_wr(1'b1, 8'(OUT_BASE), 8'hEE);
        host_wr(1'b1, 8'(OUT_BASE + 1), 8'hEE);
        @(negedge clk) b_start = 1'b1;
        @(posedge clk);
        #1 b_start = 1'b0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(posedge clk);
            #1;
            if (b_done !== (cyc == 6) || b_busy !== (cyc <= 6)) begin
                n_errors++;
                $display("FAIL single_timing cw=%h cyc=%0d: done=%b busy=%b required %b %b",
                         cw, cyc, b_done, b_busy, cyc == 6, cyc <= 6);
            end
            n_checks++;
        end
        if (mem_b[OUT_BASE] !== exp[7:0] || mem_b[OUT_BASE + 1] !== exp[15:8]) begin
            n_errors++;
            $display("FAIL single_data cw=%h: lo=%h hi=%h required %h %h", cw, mem_b[OUT_BASE],
                     mem_b[OUT_BASE + 1], exp[7:0], exp[15:8]);
        end
        n_checks++;
`ifdef SECDED_STATS_EN
        exp_s = (exp[15:14] == 2'b01) ? 1 : 0;
        exp_d = (exp[15:14] == 2'b10) ? 1 : 0;
`else
        exp_s = 0;
        exp_d = 0;
`endif
        if (int'(b_sgl) != exp_s || int'(b_dbl) != exp_d) begin
            n_errors++;
            $display("FAIL single_cnt cw=%h: sgl=%0d dbl=%0d required %0d %0d", cw, b_sgl, b_dbl,
                     exp_s, exp_d);
        end
        n_checks++;
    endtask

    task automatic test_directed();
        logic [15:0] list [5];
        list[0] = 16'h0000; list[1] = 16'h0008; list[2] = 16'h0018;
        list[3] = 16'h0001; list[4] = 16'hFFFF;
        for (int i = 0; i < 5; i++) test_single(list[i]);
        for (int i = 0; i < 6; i++) test_single(rand_word(i % 3));
    endtask

    // Runs one full 15-word pass on DUT A with the words already loaded.
    task automatic test_full_run(input bit mid_start);
        logic [15:0] exp;
        int          ns, nd, ph, w;
        logic [7:0]  ea;
        @(negedge clk) a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        for (int cyc = 1; cyc <= int'(NW) * 6 + 5; cyc++) begin
            @(posedge clk);
            #1;
            a_start = (mid_start && (cyc == 40 || cyc == 77)) ? 1'b1 : 1'b0;
            ph = cyc % 6;
            w  = cyc / 6;
            if (a_busy !== (cyc <= int'(NW) * 6) || a_done !== (cyc == int'(NW) * 6) ||
                a_we !== (cyc < int'(NW) * 6 && ph >= 4)) begin
                n_errors++;
                $display("FAIL run_ctrl cyc=%0d: busy=%b done=%b we=%b", cyc, a_busy, a_done,
                         a_we);
            end
            n_checks++;
            if (cyc < int'(NW) * 6 && ph >= 4) begin
                ea = 8'(OUT_BASE + 2 * w + ph - 4);
                if (a_addr !== ea) begin
                    n_errors++;
                    $display("FAIL run_waddr cyc=%0d: addr=%h required %h", cyc, a_addr, ea);
                end
                n_checks++;
            end
        end
        a_start = 1'b0;
        ns = 0;
        nd = 0;
        for (int i = 0; i < int'(NW); i++) begin
            exp = ref_decode(words[i]);
            if (exp[15:14] == 2'b01) ns++;
            if (exp[15:14] == 2'b10) nd++;
            if (mem_a[OUT_BASE + 2 * i] !== exp[7:0] ||
                mem_a[OUT_BASE + 2 * i + 1] !== exp[15:8]) begin
                n_errors++;
                $display("FAIL run_data word %0d cw=%h: lo=%h hi=%h required %h %h", i, words[i],
                         mem_a[OUT_BASE + 2 * i], mem_a[OUT_BASE + 2 * i + 1], exp[7:0],
                         exp[15:8]);
            end
            n_checks++;
        end
`ifndef SECDED_STATS_EN
        ns = 0;
        nd = 0;
`endif
        if (int'(a_sgl) != ns || int'(a_dbl) != nd) begin
            n_errors++;
            $display("FAIL run_cnt: sgl=%0d dbl=%0d required %0d %0d", a_sgl, a_dbl, ns, nd);
        end
        n_checks++;
    endtask

    task automatic gen_words();
        for (int i = 0; i < int'(NW); i++) words[i] = rand_word((i < 3) ? i : $urandom_range(0, 2));
    endtask

    task automatic test_back_to_back();
        gen_words();
        load_a();
        test_full_run(1'b1);
        gen_words();
        load_a();
        test_full_run(1'b0);
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] exp;
        gen_words();
        load_a();
        exp = ref_decode(words[5]);
        @(negedge clk) a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        for (int cyc = 1; cyc <= 34; cyc++) begin
            @(posedge clk);
            #1;
        end
        if (a_we !== 1'b1 || a_addr !== 8'(OUT_BASE + 10) || a_wdata !== exp[7:0]) begin
            n_errors++;
            $display("FAIL rst_pre: we=%b addr=%h wdata=%h required 1 %h %h", a_we, a_addr,
                     a_wdata, 8'(OUT_BASE + 10), exp[7:0]);
        end
        n_checks++;
        rst_n = 1'b0;
        #1;
        if (a_we !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_addr !== 8'h00) begin
            n_errors++;
            $display("FAIL rst_async: we=%b busy=%b done=%b addr=%h required 0 0 0 00", a_we,
                     a_busy, a_done, a_addr);
        end
        n_checks++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        if (a_busy !== 1'b0 || mem_a[OUT_BASE + 10] !== 8'hEE) begin
            n_errors++;
            $display("FAIL rst_after: busy=%b out[10]=%h required 0 ee", a_busy,
                     mem_a[OUT_BASE + 10]);
        end
        n_checks++;
        // Fresh poison in the output area proves the restart covers word 0 onward.
        load_a();
        test_full_run(1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk) rst_n = 1'b1;
        test_directed();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
